// File: rtl/i2c_reg_access.sv
// I2C register-access master: START, slave address with ACK polling, pointer, write payload or repeated-start read, STOP.
// Latency: START to END_OK = 4+36*N cycles for a write, 7+36*(N1+N2) for a read, plus 40 cycles per address retry.
// Backpressure: none; GO is honoured only as a high-then-low sequence while idle and is ignored while busy.
module i2c_reg_access #(
    parameter int PTR_BYTES  = 1,
    parameter int DATA_BYTES = 1,
    parameter int MAX_RETRY  = 255
) (
    input  logic                    PT_CK,
    input  logic                    RESET_N,
    input  logic                    GO,
    input  logic                    RW,
    input  logic [7:0]              SLAVE_ADDRESS,
    input  logic [8*PTR_BYTES-1:0]  POINTER,
    input  logic [8*DATA_BYTES-1:0] WDATA,
    input  logic                    SDAI,
    output logic                    SDAO,
    output logic                    SCLO,
    output logic                    END_OK,
    output logic                    ACK_OK,
    output logic                    NACK_ERR,
    output logic [8*DATA_BYTES-1:0] RDATA,
    output logic [7:0]              RETRY_CNT
);
    localparam int TXW = 8*(1+PTR_BYTES+DATA_BYTES);
    localparam int RXW = 8*DATA_BYTES;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_START, S_BIT, S_RSTART, S_STOP, S_RETRY, S_DONE
    } state_t;

    state_t         state, state_n;
    logic [1:0]     sub;        // bit phase in S_BIT, step in RSTART/STOP/RETRY
    logic [3:0]     bit_idx;    // 0..7 data bits, 8 = ACK bit
    logic [2:0]     byte_cnt;   // byte index within the current START segment
    logic           seg2;       // after the repeated start of a read
    logic           rw_q;
    logic           err_q;
    logic           sda_hold;   // SDA value of the previous cycle, held through ph0
    logic [6:0]     addr_q;
    logic [TXW-1:0] tx_sr;      // outgoing bytes, current byte in the top 8 bits
    logic [RXW-1:0] rx_sr;

    logic [7:0]     cur_byte;
    logic [2:0]     seg_bytes;
    logic           rd_byte, ack_bit, last_byte, bit_val, retry_ok;
    logic           launch, byte_ok, nack_fail, do_retry, finish;

    assign cur_byte  = tx_sr[TXW-1 -: 8];
    assign rd_byte   = seg2 && (byte_cnt != 3'd0);
    assign ack_bit   = (bit_idx == 4'd8);
    assign seg_bytes = seg2 ? 3'(1+DATA_BYTES)
                     : (rw_q ? 3'(1+PTR_BYTES) : 3'(1+PTR_BYTES+DATA_BYTES));
    assign last_byte = (byte_cnt == seg_bytes - 3'd1);
    // Slave-driven bits are released; on read bytes the master ACKs all but the last byte.
    assign bit_val   = ack_bit ? (rd_byte ? last_byte : 1'b1)
                               : (rd_byte ? 1'b1 : cur_byte[3'd7 - bit_idx[2:0]]);
    assign retry_ok  = (int'(RETRY_CNT) < MAX_RETRY);

    // State register; sub restarts whenever the state changes and wraps inside S_BIT.
    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            sub   <= 2'd0;
        end else begin
            state <= state_n;
            sub   <= (state_n == state) ? sub + 2'd1 : 2'd0;
        end
    end

    // Next state, bus pins and sequencing strobes.
    always_comb begin
        state_n   = state;
        SDAO      = 1'b1;
        SCLO      = 1'b1;
        launch    = 1'b0;
        byte_ok   = 1'b0;
        nack_fail = 1'b0;
        do_retry  = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE:  if (GO) state_n = S_ARM;
            S_ARM: begin
                if (!GO) begin
                    state_n = S_START;
                    launch  = 1'b1;
                end
            end
            S_START: begin
                SDAO    = 1'b0;
                state_n = S_BIT;
            end
            S_BIT: begin
                SCLO = sub[1];
                SDAO = (sub == 2'd0) ? sda_hold : bit_val;
                if (sub == 2'd3 && ack_bit) begin
                    if (!rd_byte && SDAI) begin
                        if (!seg2 && byte_cnt == 3'd0 && retry_ok) begin
                            do_retry = 1'b1;
                            state_n  = S_RETRY;
                        end else begin
                            nack_fail = 1'b1;
                            state_n   = S_STOP;
                        end
                    end else begin
                        byte_ok = 1'b1;
                        if (last_byte)
                            state_n = (!seg2 && rw_q) ? S_RSTART : S_STOP;
                    end
                end
            end
            S_RSTART: begin
                SDAO = (sub != 2'd2);
                SCLO = (sub != 2'd0);
                if (sub == 2'd2) state_n = S_BIT;
            end
            S_STOP, S_RETRY: begin
                SDAO = (sub == 2'd2);
                SCLO = (sub != 2'd0);
                if (sub == 2'd2) begin
                    state_n = (state == S_STOP) ? S_DONE : S_START;
                    finish  = (state == S_STOP);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Command latch, shift registers, counters and status reporting.
    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_idx   <= 4'd0;
            byte_cnt  <= 3'd0;
            seg2      <= 1'b0;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
            sda_hold  <= 1'b1;
            addr_q    <= 7'd0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            END_OK    <= 1'b1;
            ACK_OK    <= 1'b0;
            NACK_ERR  <= 1'b0;
            RDATA     <= '0;
            RETRY_CNT <= 8'd0;
        end else begin
            sda_hold <= SDAO;
            if (launch) begin
                rw_q      <= RW;
                addr_q    <= SLAVE_ADDRESS[7:1];
                tx_sr     <= {SLAVE_ADDRESS & 8'hFE, POINTER, WDATA};
                seg2      <= 1'b0;
                err_q     <= 1'b0;
                bit_idx   <= 4'd0;
                byte_cnt  <= 3'd0;
                END_OK    <= 1'b0;
                ACK_OK    <= 1'b0;
                NACK_ERR  <= 1'b0;
                RETRY_CNT <= 8'd0;
            end
            if (state == S_BIT && sub == 2'd3) begin
                bit_idx <= ack_bit ? 4'd0 : bit_idx + 4'd1;
                if (rd_byte && !ack_bit) rx_sr <= {rx_sr[RXW-2:0], SDAI};
            end
            if (byte_ok) begin
                byte_cnt <= byte_cnt + 3'd1;
                tx_sr    <= {tx_sr[TXW-9:0], 8'h00};
            end
            if (state == S_RSTART) begin
                seg2               <= 1'b1;
                byte_cnt           <= 3'd0;
                tx_sr[TXW-1 -: 8]  <= {addr_q, 1'b1};
            end
            if (do_retry && RETRY_CNT != 8'hFF) RETRY_CNT <= RETRY_CNT + 8'd1;
            if (nack_fail) err_q <= 1'b1;
            if (finish) begin
                END_OK   <= 1'b1;
                ACK_OK   <= !err_q;
                NACK_ERR <= err_q;
                if (!err_q && rw_q) RDATA <= rx_sr;
            end
        end
    end
endmodule

// File: doc/i2c_reg_access.md
# i2c_reg_access

Parametrised I2C register-access master for camera/sensor configuration, succeeding the single-pointer write-only block. It supports multi-byte register pointers, multi-byte write and read payloads with repeated start, per-byte ACK checking with error reporting, and bounded ACK polling on the slave-address byte for slaves that are still waking up. It sits between the configuration sequencer, which drives GO and the command fields, and the open-drain SDA/SCL pad logic.

## Interface
- PTR_BYTES, 1: register pointer length in bytes (1..2), sent MSB byte first.
- DATA_BYTES, 1: payload length in bytes (1..4), MSB byte first.
- MAX_RETRY, 255: number of extra address attempts after a NACK (0 = no polling).

- PT_CK  in  1  bit-phase clock (4 PT_CK cycles per SCL bit).
- RESET_N  in  1  asynchronous, active-low reset.
- GO  in  1  command strobe: transaction launches on the first cycle GO is sampled low after being sampled high while idle.
- RW  in  1  0 = register write, 1 = register read.
- SLAVE_ADDRESS  in  8  8-bit bus address; bit 0 is ignored and replaced by the R/W bit.
- POINTER  in  8*PTR_BYTES  register pointer.
- WDATA  in  8*DATA_BYTES  write payload.
- SDAI  in  1  sampled SDA pad.
- SDAO  out  1  SDA drive (1 = release).
- SCLO  out  1  SCL drive (1 = release).
- END_OK  out  1  1 = idle/done, 0 = busy.
- ACK_OK  out  1  1 = last transaction completed with every slave ACK.
- NACK_ERR  out  1  1 = last transaction aborted on NACK or retry exhaustion.
- RDATA  out  8*DATA_BYTES  read payload, MSB byte first.
- RETRY_CNT  out  8  address retries used by the last transaction (saturates at 255).

## Operation
- Reset values: SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, NACK_ERR=0, RDATA=0, RETRY_CNT=0. State returns to IDLE.
- States: IDLE, ARM, START, BIT(phase 0..3), RSTART, STOP, RETRY, DONE.
- IDLE: GO=1 moves to ARM. ARM: GO=0 latches RW, SLAVE_ADDRESS, POINTER and WDATA; clears ACK_OK, NACK_ERR and RETRY_CNT; sets END_OK=0; then enters START.
- START (1 cycle): SDAO=0, SCLO=1.
- Byte transfer = 8 data bits plus 1 ACK bit, each bit 4 cycles:
  - ph0: SCLO=0.
  - ph1: SDAO is set to the bit value; for a slave ACK or a read data bit, SDAO=1.
  - ph2: SCLO=1.
  - ph3: SCLO stays 1 and SDAI is sampled on this edge; SCLO=0 from the next ph0.
- Write sequence: START, {addr,0}, POINTER bytes, WDATA bytes, STOP.
- Read sequence: START, {addr,0}, POINTER bytes, RSTART, {addr,1}, DATA_BYTES read bytes, STOP.
  - On read bytes, the master drives the ACK bit: SDAO=0 on every byte except the last, SDAO=1 (NACK) on the last.
- RSTART (3 cycles): (SDAO,SCLO) = (1,0), (1,1), (0,1).
- STOP (3 cycles): (0,0), (0,1), (1,1).
- ACK polling (first address byte only):
  - If the ACK sample is 1, go to RETRY: STOP, then START, and resend the address.
  - RETRY_CNT increments on each retry.
  - If the retry count would exceed MAX_RETRY, STOP and finish with NACK_ERR=1.
- A NACK on any pointer byte, write-data byte or second address byte goes to STOP and finishes with NACK_ERR=1, ACK_OK=0.
- DONE (1 cycle): END_OK=1; ACK_OK = !NACK_ERR. RDATA is loaded from the shift register only on a successful read, otherwise it is left unchanged. Returns to IDLE.
- GO activity while busy is ignored. A new command requires a fresh high-then-low GO sequence after END_OK=1.

## Timing
- Bytes per transaction: write N = 1+PTR_BYTES+DATA_BYTES. Read: N1 = 1+PTR_BYTES before RSTART, N2 = 1+DATA_BYTES after.
- END_OK rises this many cycles after the START cycle (START cycle counted as cycle 0), with no retries:
  - write: 1+36N+3;
  - read: 1+36·N1+3+36·N2+3.
- Each retry adds 36+3+1 = 40 cycles.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronous). No STOP is generated.
- SDAO changes only while SCLO=0, except in START, RSTART and STOP.

## Test plan
- Write, PTR_BYTES=1, DATA_BYTES=1, addr 0x6C, ptr 0x12, data 0xA5, slave always ACKs -> serialised bits 0x6C, 0x12, 0xA5; END_OK rises 112 cycles after START; ACK_OK=1, NACK_ERR=0.
- Read, PTR_BYTES=2, DATA_BYTES=2, ptr 0x3008, slave returns 0xBEEF -> RSTART after pointer; address byte 0x6D; master ACK after the first read byte, NACK after the last; RDATA=0xBEEF; END_OK rises at 1+108+3+108+3 = 223 cycles.
- Slave NACKs the address 3 times, then ACKs, MAX_RETRY=5 -> RETRY_CNT=3, ACK_OK=1, total latency 112+120 = 232 cycles.
- Slave NACKs the address always, MAX_RETRY=2 -> RETRY_CNT=2, NACK_ERR=1, ACK_OK=0, final bus state SDAO=1, SCLO=1.
- NACK on the data byte of a write -> immediate STOP after that ACK bit; NACK_ERR=1; RDATA unchanged.
- RESET_N pulsed low mid-pointer byte -> SDAO=1, SCLO=1, END_OK=1 asynchronously; a following GO high/low pulse runs a clean transaction.
